// File: rtl/instruction_memory_if.sv
// instruction_memory_if: host write bus and controller read bus of the program store.
// master = host/controller side, slave = instruction_memory.
interface instruction_memory_if #(
  parameter int ADDR_W = 10,
  parameter int ARG_W  = 11
);
  localparam int W = ARG_W + 5;

  logic              wr_en;
  logic [W-1:0]      wr_data;
  logic              wr_clr;
  logic              wr_full;
  logic              wr_ovf;
  logic [ADDR_W:0]   word_count;
  logic              mem_read;
  logic              mem_zero;
  logic              mem_valid;
  logic [3:0]        dev_no;
  logic              dev_op_rst;
  logic [ARG_W-1:0]  dev_arg;

  modport master (
    output wr_en, wr_data, wr_clr,
    output mem_read, mem_zero,
    input  wr_full, wr_ovf, word_count,
    input  mem_valid, dev_no, dev_op_rst, dev_arg
  );

  modport slave (
    input  wr_en, wr_data, wr_clr,
    input  mem_read, mem_zero,
    output wr_full, wr_ovf, word_count,
    output mem_valid, dev_no, dev_op_rst, dev_arg
  );
endinterface

// File: rtl/instruction_memory.sv
// instruction_memory: host appends words, controller pops/rewinds a prefetched head.
// Ports: clk, rst (async active-low), bus (instruction_memory_if.slave).
module instruction_memory #(
  parameter int ADDR_W = 10,
  parameter int ARG_W  = 11
) (
  input  logic clk,
  input  logic rst,
  instruction_memory_if.slave bus
);
  localparam int W     = ARG_W + 5;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

  logic [W-1:0]      ram_q [DEPTH];
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              ovf_q, ovf_d;
  logic [W-1:0]      head_q, head_d;
  logic              full;
  logic              wr_acc;
  logic              valid;
  logic              byp;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  always_comb begin
    full    = (cnt_q == FULL_CNT);
    wr_acc  = bus.wr_en && !bus.wr_clr && !full;
    valid   = (ptr_q < cnt_q) && !bus.mem_zero;
    wr_addr = cnt_q[ADDR_W-1:0];

    ptr_d = ptr_q;
    unique case (1'b1)
      bus.mem_zero:           ptr_d = '0;
      bus.mem_read && valid:  ptr_d = ptr_q + ONE;
      default:                ptr_d = ptr_q;
    endcase

    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unique case (1'b1)
      bus.wr_clr: begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end
      !bus.wr_clr && bus.wr_en && full:
        ovf_d = 1'b1;
      wr_acc:
        cnt_d = cnt_q + ONE;
      default: begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
      end
    endcase

    // Prefetch the word rd_ptr will point at; a same-edge write
    // to that slot must win over the stale RAM contents.
    rd_addr = ptr_d[ADDR_W-1:0];
    byp     = wr_acc && (cnt_q == ptr_d);
    head_d  = byp ? bus.wr_data : ram_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_acc) ram_q[wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      ptr_q  <= '0;
      ovf_q  <= 1'b0;
      head_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      ovf_q  <= ovf_d;
      head_q <= head_d;
    end
  end

  assign bus.wr_full    = full;
  assign bus.wr_ovf     = ovf_q;
  assign bus.word_count = cnt_q;
  assign bus.mem_valid  = valid;
  assign bus.dev_no     = head_q[W-1 -: 4];
  assign bus.dev_op_rst = head_q[ARG_W];
  assign bus.dev_arg    = head_q[ARG_W-1:0];
endmodule

// File: tb/tb_instruction_memory.sv
// tb_instruction_memory: scoreboard bench for instruction_memory.
// Queue-based program model; monitor compares on every falling edge.
module tb_instruction_memory;
  localparam int AW    = 4;
  localparam int AR    = 11;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instruction_memory_if #(.ADDR_W(AW), .ARG_W(AR)) bus();

  instruction_memory #(.ADDR_W(AW), .ARG_W(AR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          valid;
    bit          chk_head;
    logic [15:0] head;
    int          cnt;
    bit          full;
    bit          ovf;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;

  logic [15:0] prog[$];
  int          ptr = 0;
  bit          ovf = 0;

  function automatic void chk(string nm, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("mem_valid", longint'(bus.mem_valid), longint'(e.valid));
      chk("word_count", longint'(bus.word_count), longint'(e.cnt));
      chk("wr_full", longint'(bus.wr_full), longint'(e.full));
      chk("wr_ovf", longint'(bus.wr_ovf), longint'(e.ovf));
      if (e.chk_head)
        chk("head", longint'({bus.dev_no, bus.dev_op_rst, bus.dev_arg}),
            longint'(e.head));
    end
  end

  task automatic cyc(input bit we, input logic [15:0] wd,
                     input bit clr, input bit rd, input bit z);
    exp_t e;
    bit   have;
    @(posedge clk);
    #1;
    bus.wr_en    = we;
    bus.wr_data  = wd;
    bus.wr_clr   = clr;
    bus.mem_read = rd;
    bus.mem_zero = z;
    have       = ptr < prog.size();
    e.valid    = have && !z;
    e.chk_head = have;
    e.head     = have ? prog[ptr] : 16'h0;
    e.cnt      = prog.size();
    e.full     = prog.size() == DEPTH;
    e.ovf      = ovf;
    sbq.push_back(e);
    if (z) ptr = 0;
    else if (rd && e.valid) ptr++;
    if (clr) begin
      prog.delete();
      ovf = 0;
    end else if (we) begin
      if (prog.size() == DEPTH) ovf = 1;
      else prog.push_back(wd);
    end
  endtask

  task automatic idle();
    cyc(0, 16'h0, 0, 0, 0);
  endtask

  task automatic wr(input logic [15:0] wd);
    cyc(1, wd, 0, 0, 0);
  endtask

  task automatic areset();
    @(negedge clk);
    #2;
    bus.wr_en    = 1'b0;
    bus.wr_clr   = 1'b0;
    bus.mem_zero = 1'b0;
    bus.mem_read = 1'b1;
    rst = 1'b0;
    #1;
    chk("arst_valid", longint'(bus.mem_valid), 0);
    chk("arst_count", longint'(bus.word_count), 0);
    chk("arst_head", longint'({bus.dev_no, bus.dev_op_rst, bus.dev_arg}), 0);
    chk("arst_ovf", longint'(bus.wr_ovf), 0);
    prog.delete();
    ptr = 0;
    ovf = 0;
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.wr_en    = 1'b0;
    bus.wr_data  = 16'h0;
    bus.wr_clr   = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_zero = 1'b0;
    #2;
    chk("rst_count", longint'(bus.word_count), 0);
    chk("rst_valid", longint'(bus.mem_valid), 0);
    chk("rst_ovf", longint'(bus.wr_ovf), 0);
    chk("rst_full", longint'(bus.wr_full), 0);
    chk("rst_head", longint'({bus.dev_no, bus.dev_op_rst, bus.dev_arg}), 0);
    #20;
    @(negedge clk);
    rst = 1'b1;

    // basic program and pops
    wr(16'h1800);
    wr(16'h2005);
    wr(16'h7000);
    cyc(0, 0, 0, 0, 1);
    idle();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0);
      idle();
    end
    idle();

    // rewind mid-program, then rewind together with a pop
    cyc(0, 0, 0, 0, 1);
    idle();
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    idle();
    cyc(0, 0, 0, 0, 1);
    idle();
    cyc(0, 0, 0, 1, 1);
    idle();
    idle();

    // fill, overflow, clear
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) wr(16'($urandom));
    wr(16'hbeef);
    idle();
    cyc(1, 16'h1234, 1, 0, 0);
    idle();

    // append at the head after the program ran dry
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1);
    wr(16'h1111);
    idle();
    cyc(0, 0, 0, 1, 0);
    idle();
    wr(16'h3123);
    idle();
    idle();

    // async reset mid-stream
    cyc(0, 0, 0, 0, 1);
    wr(16'h4abc);
    wr(16'h5def);
    idle();
    areset();
    cyc(0, 0, 0, 1, 0);
    idle();
    wr(16'h6111);
    wr(16'h8222);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    idle();

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 9) < 4, 16'($urandom),
          $urandom_range(0, 63) == 0,
          $urandom_range(0, 9) < 4,
          $urandom_range(0, 15) == 0);
    end
    idle();
    idle();
    @(negedge clk);
    #1;
    chk("sb_drain", longint'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
